// File: rtl/ret_stack_pkg.sv
// ret_stack_pkg: stack operation encoding shared by the return-address stack and the decoder.
package ret_stack_pkg;
  typedef enum logic [1:0] {SOP_NONE, SOP_PUSH, SOP_POP, SOP_SWAP} stack_op_t;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: circular return-address stack with zero-latency top read and sticky error flags.
`ifndef RET_STACK_SV
`define RET_STACK_SV
module ret_stack
  import ret_stack_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic clr_err,
  input  logic [A_WIDTH-1:0] push_addr,
  output logic [A_WIDTH-1:0] top_addr,
  output logic [$clog2(DEPTH):0] count,
  output logic empty,
  output logic full,
  output logic overflow,
  output logic underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DCNT = (PW+1)'(DEPTH);
  logic [A_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] tp, tp_dec;
  stack_op_t op;
  assign op = push && pop ? SOP_SWAP : push ? SOP_PUSH : pop ? SOP_POP : SOP_NONE;
  assign tp_dec = tp - 1'b1;
  assign top_addr = mem[tp_dec];
  assign empty = count == '0;
  assign full = count == DCNT;
  always_ff @(posedge clk) begin
    if (rst) begin
      tp <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (clr_err) begin
        overflow <= 1'b0;
        underflow <= 1'b0;
      end
      // errors raised below override a same-cycle clr_err
      if (flush) begin
        tp <= '0;
        count <= '0;
      end else if (op == SOP_SWAP && !empty) begin
        mem[tp_dec] <= push_addr;
      end else if (op == SOP_PUSH || op == SOP_SWAP) begin
        mem[tp] <= push_addr;
        tp <= tp + 1'b1;
        if (full) overflow <= 1'b1;
        else count <= count + 1'b1;
        if (op == SOP_SWAP) underflow <= 1'b1;
      end else if (op == SOP_POP) begin
        if (empty) underflow <= 1'b1;
        else begin
          tp <= tp_dec;
          count <= count - 1'b1;
        end
      end
    end
  end
endmodule
`endif

// File: tb/tb_ret_stack.sv
// tb_ret_stack: directed scenario tasks with hand-computed expectations for ret_stack.
module tb_ret_stack;
  logic clk = 0, rst = 0, push = 0, pop = 0, flush = 0, clr_err = 0;
  logic [7:0] push_addr = 0, top_addr;
  logic [3:0] count;
  logic empty, full, overflow, underflow;
  int pass = 0, total = 0;

  ret_stack #(.A_WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
    .push_addr(push_addr), .top_addr(top_addr), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic p, input logic q, input logic f,
                     input logic c, input logic [7:0] a);
    rst = r; push = p; pop = q; flush = f; clr_err = c; push_addr = a;
    @(posedge clk);
    #1;
    rst = 0; push = 0; pop = 0; flush = 0; clr_err = 0; push_addr = 0;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0, 0, 0);
    total++; if (top_addr !== 8'h00) $display("FAIL reset_top got %h exp 00", top_addr); else pass++;
    total++; if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count); else pass++;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else pass++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else pass++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b exp 0", overflow); else pass++;
    total++; if (underflow !== 1'b0) $display("FAIL reset_udf got %b exp 0", underflow); else pass++;
  endtask

  task automatic test_lifo;
    logic [7:0] exp_top [3];
    exp_top = '{8'h30, 8'h20, 8'h10};
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 8'h10);
    total++; if (top_addr !== 8'h10) $display("FAIL lifo_push1_top got %h exp 10", top_addr); else pass++;
    cyc(0, 1, 0, 0, 0, 8'h20);
    cyc(0, 1, 0, 0, 0, 8'h30);
    total++; if (top_addr !== 8'h30) $display("FAIL lifo_top got %h exp 30", top_addr); else pass++;
    total++; if (count !== 4'd3) $display("FAIL lifo_count got %0d exp 3", count); else pass++;
    for (int i = 0; i < 3; i++) begin
      total++; if (top_addr !== exp_top[i]) $display("FAIL lifo_pop%0d got %h exp %h", i, top_addr, exp_top[i]); else pass++;
      cyc(0, 0, 1, 0, 0, 0);
    end
    total++; if (empty !== 1'b1) $display("FAIL lifo_empty got %b exp 1", empty); else pass++;
    total++; if (underflow !== 1'b0) $display("FAIL lifo_udf got %b exp 0", underflow); else pass++;
  endtask

  task automatic test_wrap;
    logic [7:0] e;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) cyc(0, 1, 0, 0, 0, 8'(i));
    total++; if (full !== 1'b1) $display("FAIL wrap_full got %b exp 1", full); else pass++;
    total++; if (overflow !== 1'b1) $display("FAIL wrap_ovf got %b exp 1", overflow); else pass++;
    total++; if (count !== 4'd8) $display("FAIL wrap_count got %0d exp 8", count); else pass++;
    for (int i = 0; i < 8; i++) begin
      e = 8'(10 - i);
      total++; if (top_addr !== e) $display("FAIL wrap_pop%0d got %h exp %h", i, top_addr, e); else pass++;
      cyc(0, 0, 1, 0, 0, 0);
    end
    total++; if (count !== 4'd0) $display("FAIL wrap_drained got %0d exp 0", count); else pass++;
    total++; if (underflow !== 1'b0) $display("FAIL wrap_udf_early got %b exp 0", underflow); else pass++;
    cyc(0, 0, 1, 0, 0, 0);
    total++; if (underflow !== 1'b1) $display("FAIL wrap_udf got %b exp 1", underflow); else pass++;
    total++; if (count !== 4'd0) $display("FAIL wrap_count_udf got %0d exp 0", count); else pass++;
  endtask

  task automatic test_swap;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 8'h40);
    cyc(0, 1, 1, 0, 0, 8'h55);
    total++; if (top_addr !== 8'h55) $display("FAIL swap_top got %h exp 55", top_addr); else pass++;
    total++; if (count !== 4'd1) $display("FAIL swap_count got %0d exp 1", count); else pass++;
    total++; if (underflow !== 1'b0) $display("FAIL swap_udf got %b exp 0", underflow); else pass++;
    cyc(0, 0, 1, 0, 0, 0);
    total++; if (top_addr !== 8'h00) $display("FAIL swap_below got %h exp 00", top_addr); else pass++;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 8'h55);
    total++; if (underflow !== 1'b1) $display("FAIL swap_empty_udf got %b exp 1", underflow); else pass++;
    total++; if (count !== 4'd1) $display("FAIL swap_empty_count got %0d exp 1", count); else pass++;
    total++; if (top_addr !== 8'h55) $display("FAIL swap_empty_top got %h exp 55", top_addr); else pass++;
  endtask

  task automatic test_flush;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 8'h11);
    cyc(0, 1, 0, 0, 0, 8'h22);
    cyc(0, 1, 0, 1, 0, 8'h33);
    total++; if (count !== 4'd0) $display("FAIL flush_count got %0d exp 0", count); else pass++;
    total++; if (empty !== 1'b1) $display("FAIL flush_empty got %b exp 1", empty); else pass++;
    total++; if (top_addr !== 8'h00) $display("FAIL flush_top got %h exp 00", top_addr); else pass++;
    total++; if (underflow !== 1'b1) $display("FAIL flush_udf_kept got %b exp 1", underflow); else pass++;
    total++; if (overflow !== 1'b0) $display("FAIL flush_ovf got %b exp 0", overflow); else pass++;
    cyc(0, 1, 0, 0, 0, 8'h66);
    total++; if (top_addr !== 8'h66) $display("FAIL flush_repush got %h exp 66", top_addr); else pass++;
  endtask

  task automatic test_clr_err;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 0, 8'(8'hA0 + i));
    total++; if (overflow !== 1'b1) $display("FAIL clr_ovf_set got %b exp 1", overflow); else pass++;
    cyc(0, 0, 0, 0, 1, 0);
    total++; if (overflow !== 1'b0) $display("FAIL clr_ovf got %b exp 0", overflow); else pass++;
    total++; if (count !== 4'd8) $display("FAIL clr_count got %0d exp 8", count); else pass++;
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 0);
    total++; if (underflow !== 1'b1) $display("FAIL clr_udf_wins got %b exp 1", underflow); else pass++;
    cyc(0, 0, 0, 0, 1, 0);
    total++; if (underflow !== 1'b0) $display("FAIL clr_udf got %b exp 0", underflow); else pass++;
  endtask

  task automatic test_rst_mid;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 8'h77);
    cyc(0, 1, 0, 0, 0, 8'h88);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 8'h99);
    total++; if (top_addr !== 8'h00) $display("FAIL rst_top got %h exp 00", top_addr); else pass++;
    total++; if (count !== 4'd0) $display("FAIL rst_count got %0d exp 0", count); else pass++;
    total++; if (empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty); else pass++;
    total++; if (underflow !== 1'b0) $display("FAIL rst_udf got %b exp 0", underflow); else pass++;
    cyc(0, 1, 0, 0, 0, 8'h05);
    total++; if (top_addr !== 8'h05) $display("FAIL rst_push_top got %h exp 05", top_addr); else pass++;
    total++; if (count !== 4'd1) $display("FAIL rst_push_count got %0d exp 1", count); else pass++;
  endtask

  initial begin
    test_reset;
    test_lifo;
    test_wrap;
    test_swap;
    test_flush;
    test_clr_err;
    test_rst_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/ret_stack.md
# ret_stack

Hardware return-address stack for the v1 core. On a call it stores the PC's incremented address; on a return it supplies that address as the jump target in the same cycle. It sits beside `pc`: its `push_addr` input takes the PC's `incremented` output, and its `top_addr` output feeds the PC's `jump_addr` multiplexer for return instructions. Storage is circular, so deep recursion overwrites the oldest entries rather than stalling.

## Interface
- `A_WIDTH`, default 8: address width; matches the PC.
- `DEPTH`, default 8: number of entries; a power of two, ≥2.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `push`  in  1: call; store `push_addr`.
- `pop`  in  1: return; discard the top entry.
- `flush`  in  1: empty the stack (exception or context switch).
- `clr_err`  in  1: clear the sticky error flags.
- `push_addr`  in  A_WIDTH: return address to store.
- `top_addr`  out  A_WIDTH: current top entry, combinational from storage.
- `count`  out  $clog2(DEPTH)+1: valid entries, 0..DEPTH.
- `empty`  out  1: `count == 0`.
- `full`  out  1: `count == DEPTH`.
- `overflow`  out  1: sticky; an entry was overwritten.
- `underflow`  out  1: sticky; a pop was issued while empty.

## Operation
- State:
  - `mem[DEPTH]`
  - `tp`: write pointer, $clog2(DEPTH) bits, wraps modulo DEPTH.
  - `count`
  - the two sticky flags.
- `top_addr = mem[tp-1]`, modulo DEPTH. When `empty`, the value is don't-care but deterministic: entries reset to 0.
- Operation per cycle, in priority order:
  1. `rst`: `tp = 0`, `count = 0`, every `mem` entry = 0, both flags = 0.
  2. `flush`: `tp = 0`, `count = 0`. Flags unchanged. `mem` unchanged. `push` and `pop` are ignored.
  3. `push` && `pop`, non-empty: `mem[tp-1] = push_addr` (top replaced). `tp` and `count` unchanged.
  4. `push` && `pop`, empty: `underflow = 1`, then behave as a plain push.
  5. `push` only: `mem[tp] = push_addr`, `tp++`, `count = min(count+1, DEPTH)`. If already `full`: the oldest entry is overwritten, `count` stays DEPTH, `overflow = 1`.
  6. `pop` only, non-empty: `tp--`, `count--`. `mem` unchanged.
  7. `pop` only, empty: no state change except `underflow = 1`.
- `clr_err` clears both flags at the edge. A new error raised in the same cycle wins, so the flag reads 1 afterwards.
- All pointer arithmetic is unsigned and modulo DEPTH. `count` never exceeds DEPTH and never goes below 0.

## Timing
- Latency:
  - Push: one cycle. `push_addr` appears on `top_addr` after the edge.
  - Pop: zero cycles. `top_addr` is valid before the edge on which `pop` is sampled, so `pc` jumps to it in the same cycle.
  - After a pop edge, `top_addr` shows the next-older entry.
- No handshake. The stack is always ready, and `push`/`pop` are single-cycle strobes.
- Reset output values, after a `rst` edge:
  - `top_addr = 0`
  - `count = 0`
  - `empty = 1`
  - `full = 0`
  - `overflow = 0`
  - `underflow = 0`
- Reset is sampled on the clock edge only. An asserted `rst` overrides any push, pop or flush in the same cycle.
- Wrap-around: after DEPTH+k pushes, the last DEPTH addresses are retrievable in LIFO order. The (DEPTH+1)-th pop is an underflow.
- `count`, `empty` and `full` are registered. `top_addr` is a combinational read of a registered array.

## Structure
- Add `stack_op_t` (`SOP_NONE`, `SOP_PUSH`, `SOP_POP`, `SOP_SWAP`) to `enums.svh`. It is decoded internally from `{push, pop}`. The decoder also uses it to drive call/ret.
- No constants shared beyond `A_WIDTH`.
- Single module, no sub-module. Storage is an inline register array; LUT-RAM inference is acceptable provided the read stays asynchronous.
- Guard the file with ``` `ifndef RET_STACK_SV ```.

## Test plan
- Reset then 3 pushes (0x10, 0x20, 0x30) → `top_addr` 0x30, `count` 3. Then 3 pops return 0x30, 0x20, 0x10 in the pre-edge `top_addr`. `empty` = 1 at the end.
- DEPTH=8: push 0x01..0x0A (10 pushes) → `full`, `overflow` = 1, `count` 8. Then 8 pops yield 0x0A..0x03. A 9th pop sets `underflow`, and `count` stays 0.
- Push 0x40, then `push` && `pop` with 0x55 → `top_addr` 0x55, `count` 1. On an empty stack, the same strobe gives `underflow` = 1, `count` 1, `top_addr` 0x55.
- Push 0x11, 0x22, then `flush` together with `push` (0x33) → `count` 0, `empty` 1, push ignored. Flags unchanged.
- Set `overflow`, then `clr_err` → `overflow` 0. `clr_err` together with a pop while empty → `underflow` reads 1.
- Mid-sequence `rst` asserted together with `push` → all outputs at reset values the next cycle, `top_addr` 0.
